// File: rtl/pipeif_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, follows load-use stalls and ID redirects, and bubbles on imem wait states.
`timescale 1ns/1ps
module pipeif_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loaddepeen,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      bpc,
    input  logic [31:0]      rpc,
    input  logic [31:0]      jpc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0]  SRC_SEQ = 2'b00;
    localparam logic [1:0]  SRC_BPC = 2'b01;
    localparam logic [1:0]  SRC_RPC = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  target;
    logic             stall;
    logic             redirect;
    logic             wait_st;

    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  id_inst_nxt;
    logic [XLEN-1:0]  id_pc4_nxt;
    logic             id_valid_nxt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    logic [CNT_W-1:0] flush_cnt_nxt;

    assign imem_addr = pc;
    assign pc_plus4  = XLEN'(pc + XLEN'(4));

    // Cycle classification in priority order: stall, redirect, wait, normal.
    assign stall    = ~loaddepeen;
    assign redirect = loaddepeen & (pcsource != SRC_SEQ);
    assign wait_st  = loaddepeen & (pcsource == SRC_SEQ) & ~imem_ready;

    // Redirect target; low two bits are dropped to keep the PC word-aligned.
    always_comb begin
        target = jpc;
        case (pcsource)
            SRC_BPC: target = bpc;
            SRC_RPC: target = rpc;
            default: target = jpc;
        endcase
        target[1:0] = 2'b00;
    end

    always_comb begin
        pc_nxt        = pc;
        id_inst_nxt   = id_inst;
        id_pc4_nxt    = id_pc4;
        id_valid_nxt  = id_valid;
        stall_cnt_nxt = stall_cnt;
        flush_cnt_nxt = flush_cnt;

        if (stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
        end else if (redirect) begin
            pc_nxt       = target;
            id_inst_nxt  = '0;
            id_pc4_nxt   = '0;
            id_valid_nxt = 1'b0;
            if (flush_cnt != CNT_MAX) begin
                flush_cnt_nxt = flush_cnt + CNT_W'(1);
            end
        end else if (wait_st) begin
            id_inst_nxt  = '0;
            id_pc4_nxt   = '0;
            id_valid_nxt = 1'b0;
        end else begin
            pc_nxt       = pc_plus4;
            id_inst_nxt  = imem_inst;
            id_pc4_nxt   = pc_plus4;
            id_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            id_inst   <= '0;
            id_pc4    <= '0;
            id_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            pc        <= pc_nxt;
            id_inst   <= id_inst_nxt;
            id_pc4    <= id_pc4_nxt;
            id_valid  <= id_valid_nxt;
            stall_cnt <= stall_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipeif_stage.sv
// Directed bench for pipeif_stage with a synthetic instruction memory.
`timescale 1ns/1ps
module tb_pipeif_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        loaddepeen;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        imem_ready;
    logic [31:0] pc, id_inst, id_pc4;
    logic        id_valid;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC000_0000 | (a ^ 32'h0055_0000);
    endfunction

    assign imem_inst = mem(imem_addr);

    pipeif_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .loaddepeen(loaddepeen), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_addr(imem_addr),
        .imem_inst(imem_inst), .imem_ready(imem_ready), .pc(pc),
        .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                            input logic [31:0] e_pc4, input logic e_valid);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".imem_addr"}, imem_addr, e_pc);
        check({tag, ".id_inst"}, id_inst, e_inst);
        check({tag, ".id_pc4"}, id_pc4, e_pc4);
        check({tag, ".id_valid"}, 32'(id_valid), 32'(e_valid));
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] e_stall, input logic [15:0] e_flush);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e_stall));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e_flush));
    endtask

    initial begin
        rst = 1'b1; loaddepeen = 1'b1; pcsource = 2'b00;
        bpc = '0; rpc = '0; jpc = '0; imem_ready = 1'b1;

        // Reset, then free run.
        step();
        check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("reset", 16'd0, 16'd0);
        rst = 1'b0;
        step();
        check_if("run0", 32'h4, mem(32'h0), 32'h4, 1'b1);
        step();
        check_if("run1", 32'h8, mem(32'h4), 32'h8, 1'b1);
        check_cnt("run1", 16'd0, 16'd0);

        // Load-use stall with a pending branch that must be ignored.
        loaddepeen = 1'b0; pcsource = 2'b01; bpc = 32'd40; imem_ready = 1'b0;
        step();
        check_if("stall0", 32'h8, mem(32'h4), 32'h8, 1'b1);
        step();
        check_if("stall1", 32'h8, mem(32'h4), 32'h8, 1'b1);
        check_cnt("stall1", 16'd2, 16'd0);
        loaddepeen = 1'b1; pcsource = 2'b00; imem_ready = 1'b1;
        step();
        check_if("release", 32'hC, mem(32'h8), 32'hC, 1'b1);

        // Branch redirect, unaligned target.
        pcsource = 2'b01; bpc = 32'h0000_0043;
        step();
        check_if("bpc", 32'h40, 32'h0, 32'h0, 1'b0);
        check_cnt("bpc", 16'd2, 16'd1);
        pcsource = 2'b00;
        step();
        check_if("bpc_next", 32'h44, mem(32'h40), 32'h44, 1'b1);

        // jr redirect.
        pcsource = 2'b10; rpc = 32'h0000_0202;
        step();
        check_if("rpc", 32'h200, 32'h0, 32'h0, 1'b0);
        pcsource = 2'b00;
        step();
        check_if("rpc_next", 32'h204, mem(32'h200), 32'h204, 1'b1);

        // j/jal redirect.
        pcsource = 2'b11; jpc = 32'h0000_0301;
        step();
        check_if("jpc", 32'h300, 32'h0, 32'h0, 1'b0);
        check_cnt("jpc", 16'd2, 16'd3);
        pcsource = 2'b00;
        step();
        check_if("jpc_next", 32'h304, mem(32'h300), 32'h304, 1'b1);

        // Imem wait at pc=12, then redirect abandons the wait.
        pcsource = 2'b11; jpc = 32'd12;
        step();
        check_if("to12", 32'd12, 32'h0, 32'h0, 1'b0);
        pcsource = 2'b00;
        step();
        check_if("fetch12", 32'd16, mem(32'd12), 32'd16, 1'b1);
        pcsource = 2'b11; jpc = 32'd12;
        step();
        pcsource = 2'b00; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("wait", 32'd12, 32'h0, 32'h0, 1'b0);
        end
        check_cnt("wait", 16'd2, 16'd5);
        pcsource = 2'b11; jpc = 32'd100;
        step();
        check_if("wait_redir", 32'd100, 32'h0, 32'h0, 1'b0);
        check_cnt("wait_redir", 16'd2, 16'd6);
        pcsource = 2'b00; imem_ready = 1'b1;
        step();
        check_if("after_wait", 32'd104, mem(32'd100), 32'd104, 1'b1);

        // PC wrap.
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        step();
        check_if("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        pcsource = 2'b00;
        step();
        check_if("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);

        // Stall counter saturation (starts at 2).
        loaddepeen = 1'b0;
        for (int i = 0; i < 65532; i++) step();
        check_cnt("near_sat", 16'hFFFE, 16'd7);
        step();
        check_cnt("sat", 16'hFFFF, 16'd7);
        for (int i = 0; i < 4; i++) step();
        check_cnt("sat_hold", 16'hFFFF, 16'd7);
        check_if("sat_hold", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);

        // Reset in the middle of a stall.
        loaddepeen = 1'b1; pcsource = 2'b11; jpc = 32'd20;
        step();
        check_if("to20", 32'd20, 32'h0, 32'h0, 1'b0);
        pcsource = 2'b00;
        step();
        loaddepeen = 1'b0;
        step();
        check_if("stall20", 32'd24, mem(32'd20), 32'd24, 1'b1);
        rst = 1'b1;
        step();
        check_if("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("rst_stall", 16'd0, 16'd0);
        rst = 1'b0; loaddepeen = 1'b1;
        step();
        check_if("post_rst", 32'h4, mem(32'h0), 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeif_stage.md
Name: pipeif_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined CPU. It sits directly upstream of the ID control unit. It holds the PC, drives the instruction memory address, and latches the fetched instruction into ID. It obeys the ID stage's load-use stall (loaddepeen, active low) and its pcsource redirect, and inserts NOP bubbles on redirect or instruction-memory wait states. Saturating stall and flush counters support performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 00.
CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active high
loaddepeen  in  1  from ID control unit; 0 = load-use stall (hold PC and IF/ID)
pcsource  in  2  from ID: 00 pc+4, 01 bpc (beq/bne taken), 10 rpc (jr), 11 jpc (j/jal)
bpc  in  32  branch target computed in ID
rpc  in  32  jr target (rs value) from ID
jpc  in  32  j/jal target from ID
imem_addr  out  32  instruction memory address; combinational, equals pc
imem_inst  in  32  instruction word; combinational response to imem_addr
imem_ready  in  1  1 = imem_inst valid this cycle; 0 = wait state
pc  out  32  current IF-stage PC
id_inst  out  32  IF/ID instruction register
id_pc4  out  32  IF/ID PC+4 register (feeds branch/jal in ID)
id_valid  out  1  1 = id_inst is a real instruction; 0 = bubble
stall_cnt  out  CNT_W  count of stall cycles, saturating
flush_cnt  out  CNT_W  count of accepted redirects, saturating

Behaviour:
- Reset (rst=1 at posedge; overrides everything, including mid-stall or mid-wait):
  - pc=RESET_PC; id_inst=0; id_pc4=0; id_valid=0; stall_cnt=0; flush_cnt=0.
- Bubble: id_inst=32'h0000_0000 (op=0, func=0, decodes to no control asserted), id_pc4=0, id_valid=0.
- Per-cycle priority, evaluated at each posedge with rst=0:
  1. Stall (loaddepeen=0): pc, id_inst, id_pc4 and id_valid all hold. pcsource and imem_ready are ignored this cycle; the branch in ID re-evaluates when the stall releases. stall_cnt+1.
  2. Redirect (loaddepeen=1, pcsource!=00): pc <= selected target with bits [1:0] forced to 00. IF/ID <= bubble, discarding the wrong-path instruction fetched this cycle. Any pending imem wait is abandoned; no delay slot. flush_cnt+1.
  3. Wait (loaddepeen=1, pcsource=00, imem_ready=0): pc holds; IF/ID <= bubble.
  4. Normal (loaddepeen=1, pcsource=00, imem_ready=1): id_inst <= imem_inst; id_pc4 <= pc+4; id_valid <= 1; pc <= pc+4.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Counters saturate at all-ones and never wrap.
- Latency: an instruction fetched at cycle N appears on id_inst after posedge N+1. A redirect costs one bubble cycle.
- imem_addr=pc at all times, including during stall and wait.
- pcsource values are used only when loaddepeen=1; no X-propagation on ignored inputs.
- Target selection: 01 bpc, 10 rpc, 11 jpc; low two target bits are ignored.

Test Plan:
- Reset then free run: rst=1 one cycle, imem_ready=1, pcsource=00, loaddepeen=1 -> pc 0,4,8; id_pc4=4 with id_inst=mem[0] and id_valid=1 one cycle after pc=0; counters stay 0.
- Load-use stall: with id_inst=I1 and pc=8, loaddepeen=0 for 2 cycles with pcsource=01 and bpc=40 -> pc stays 8, id_inst stays I1, no redirect, stall_cnt=2; after release, normal advance.
- Branch redirect: pcsource=01, bpc=32'h0000_0043, loaddepeen=1 -> next pc=32'h40, id_valid=0, id_inst=0, flush_cnt=1; the following cycle id_inst=mem[0x40]. Repeat for 10/rpc and 11/jpc.
- Imem wait: imem_ready=0 for 3 cycles at pc=12 -> pc holds 12, 3 bubbles; redirect pcsource=11, jpc=100 during the wait -> pc=100, wait abandoned.
- Wrap and saturation: pc=32'hFFFF_FFFC normal fetch -> pc=0, id_pc4=0. Force 65536 stall cycles -> stall_cnt stays 16'hFFFF.
- Reset mid-stall: loaddepeen=0 with pc=20, rst=1 -> pc=RESET_PC, id_valid=0, both counters 0.
